ps2_key_ctrl: RTL

- Sequencing controller between the PS/2 receiver FIFO and the combinational scan-code→ASCII ROM.
- Pops bytes from the receiver and parses make/break/extended prefixes.
- Drives the ROM address and registers the ROM result.
- Tracks the currently held key and a press counter for the seven-segment display logic.

---
 rtl/ps2_key_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ps2_key_ctrl.sv
// Sequencer between the PS/2 receiver FIFO and the scan-code ROM. It parses
// make/break/extended prefixes, tracks the held key and counts key presses.
module ps2_key_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_ready,
  input  logic             ps2_overflow,
  output logic             ps2_nextdata_n,
  output logic [7:0]       rom_addr,
  input  logic [7:0]       rom_data,
  output logic             key_valid,
  output logic [7:0]       key_scan,
  output logic [7:0]       key_ascii,
  output logic             key_event,
  output logic [CNT_W-1:0] press_cnt,
  output logic             err_ovf
);

  typedef enum logic [1:0] {IDLE, FETCH, DECODE, LOOKUP} state_t;

  localparam logic [7:0] BRK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;

  state_t           state, state_d;
  logic [7:0]       byte_r, byte_d;
  logic             brk_flag, brk_d;
  logic             ext_flag, ext_d;
  logic             nextdata_d;
  logic             key_valid_d;
  logic [7:0]       key_scan_d;
  logic [7:0]       key_ascii_d;
  logic             key_event_d;
  logic [CNT_W-1:0] press_cnt_d;
  logic             err_ovf_d;

  // ROM address comes straight from the byte register so it never glitches
  assign rom_addr = byte_r;

  always_comb begin
    state_d     = state;
    byte_d      = byte_r;
    brk_d       = brk_flag;
    ext_d       = ext_flag;
    nextdata_d  = 1'b1;
    key_valid_d = key_valid;
    key_scan_d  = key_scan;
    key_ascii_d = key_ascii;
    key_event_d = 1'b0;
    press_cnt_d = press_cnt;
    err_ovf_d   = err_ovf | ps2_overflow;

    case (state)
      IDLE: begin
        if (ps2_ready) begin
          byte_d     = ps2_data;
          nextdata_d = 1'b0;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        state_d = DECODE;
      end
      DECODE: begin
        state_d = IDLE;
        if (byte_r == BRK_CODE) begin
          brk_d = 1'b1;
        end else if (byte_r == EXT_CODE) begin
          ext_d = 1'b1;
        end else if (brk_flag) begin
          if (!ext_flag && key_valid && (byte_r == key_scan)) begin
            key_valid_d = 1'b0;
          end
          brk_d = 1'b0;
          ext_d = 1'b0;
        end else if (ext_flag) begin
          ext_d = 1'b0;
        end else if (!(key_valid && (byte_r == key_scan))) begin
          // typematic repeats of the held key fall through to IDLE uncounted
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        key_scan_d  = byte_r;
        key_ascii_d = rom_data;
        key_valid_d = 1'b1;
        press_cnt_d = press_cnt + CNT_W'(1);
        key_event_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      byte_r         <= '0;
      brk_flag       <= 1'b0;
      ext_flag       <= 1'b0;
      ps2_nextdata_n <= 1'b1;
      key_valid      <= 1'b0;
      key_scan       <= '0;
      key_ascii      <= '0;
      key_event      <= 1'b0;
      press_cnt      <= '0;
      err_ovf        <= 1'b0;
    end else begin
      state          <= state_d;
      byte_r         <= byte_d;
      brk_flag       <= brk_d;
      ext_flag       <= ext_d;
      ps2_nextdata_n <= nextdata_d;
      key_valid      <= key_valid_d;
      key_scan       <= key_scan_d;
      key_ascii      <= key_ascii_d;
      key_event      <= key_event_d;
      press_cnt      <= press_cnt_d;
      err_ovf        <= err_ovf_d;
    end
  end

endmodule
